// File: rtl/game_pkg.sv
// game_pkg: shared operand constants and types for the operand collision logic
package game_pkg;
  localparam int NUM_OPS = 2;
  localparam int OP_PLUS = 0;
  localparam int OP_MINUS = 1;
  localparam int COOLDOWN_FRAMES_DEFAULT = 450;
  localparam int OP_IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  typedef logic [NUM_OPS-1:0] op_vec_t;
  typedef logic [OP_IDX_W-1:0] op_idx_t;
endpackage

// File: rtl/operand_hit_detector_if.sv
// operand_hit_detector_if: frame/pixel inputs and hit outputs of the operand collision block
interface operand_hit_detector_if;
  import game_pkg::*;
  logic startOfFrame;
  logic enable;
  logic playerDR;
  op_vec_t operandDR;
  op_vec_t singleHit;
  logic hitValid;
  op_idx_t hitOp;
  modport master (
    output startOfFrame, enable, playerDR, operandDR,
    input singleHit, hitValid, hitOp
  );
  modport slave (
    input startOfFrame, enable, playerDR, operandDR,
    output singleHit, hitValid, hitOp
  );
endinterface

// File: rtl/operand_hit_channel.sv
// operand_hit_channel: per-operand overlap counter, rising-contact detect and hit cooldown
module operand_hit_channel #(
  parameter int MIN_OVERLAP = 4,
  parameter int COOLDOWN_FRAMES = 450,
  parameter int CD_W = 9
) (
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic enable,
  input  logic player_dr,
  input  logic operand_dr,
  output logic fire
);
  logic [7:0] ov_cnt_q, ov_cnt_d;
  logic prev_hit_q, prev_hit_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic frame_hit;
  // Count overlap within the frame; evaluate and restart at each frame boundary
  always_comb begin
    frame_hit = (ov_cnt_q >= 8'(MIN_OVERLAP)) && enable;
    fire = sof && frame_hit && !prev_hit_q && (cooldown_q == '0);
    ov_cnt_d = sof ? '0
             : (player_dr && operand_dr && enable && ov_cnt_q < 8'(MIN_OVERLAP)) ? ov_cnt_q + 8'd1
             : ov_cnt_q;
    prev_hit_d = sof ? frame_hit : prev_hit_q;
    cooldown_d = fire ? CD_W'(COOLDOWN_FRAMES)
               : (sof && cooldown_q != '0) ? cooldown_q - 1'b1
               : cooldown_q;
  end
  // Channel state; reset drops any partial frame count
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      ov_cnt_q <= '0;
      prev_hit_q <= 1'b0;
      cooldown_q <= '0;
    end else begin
      ov_cnt_q <= ov_cnt_d;
      prev_hit_q <= prev_hit_d;
      cooldown_q <= cooldown_d;
    end
endmodule

// File: rtl/operand_hit_detector.sv
// operand_hit_detector: per-operand hit pulses plus priority-encoded hit index for the game controller
module operand_hit_detector #(
  parameter int MIN_OVERLAP = 4,
  parameter int COOLDOWN_FRAMES = game_pkg::COOLDOWN_FRAMES_DEFAULT,
  parameter int CD_W = 9
) (
  input logic clk,
  input logic resetN,
  operand_hit_detector_if.slave bus
);
  import game_pkg::*;
  op_vec_t fire;
  op_vec_t single_hit_q, single_hit_d;
  logic hit_valid_q, hit_valid_d;
  op_idx_t hit_op_q, hit_op_d;
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_ch
    operand_hit_channel #(
      .MIN_OVERLAP(MIN_OVERLAP),
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
      .CD_W(CD_W)
    ) u_ch (
      .clk(clk),
      .resetN(resetN),
      .sof(bus.startOfFrame),
      .enable(bus.enable),
      .player_dr(bus.playerDR),
      .operand_dr(bus.operandDR[g]),
      .fire(fire[g])
    );
  end
  // Lowest-index fire wins the index, so plus takes priority over minus
  always_comb begin
    single_hit_d = fire;
    hit_valid_d = |fire;
    hit_op_d = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) hit_op_d = fire[i] ? OP_IDX_W'(i) : hit_op_d;
  end
  // Outputs registered together so the pulse and its index line up
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      single_hit_q <= '0;
      hit_valid_q <= 1'b0;
      hit_op_q <= '0;
    end else begin
      single_hit_q <= single_hit_d;
      hit_valid_q <= hit_valid_d;
      hit_op_q <= hit_op_d;
    end
  assign bus.singleHit = single_hit_q;
  assign bus.hitValid = hit_valid_q;
  assign bus.hitOp = hit_op_q;
endmodule

// File: tb/tb_operand_hit_detector.sv
// tb_operand_hit_detector: directed checks of hit pulses, thresholds, hold-off, cooldown and reset
module tb_operand_hit_detector;
  logic clk = 1'b0;
  logic resetN;
  int checks = 0;
  int failures = 0;
  operand_hit_detector_if bus();
  operand_hit_detector #(.MIN_OVERLAP(4), .COOLDOWN_FRAMES(3), .CD_W(9)) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic overlap(input int n, input logic [1:0] m);
    repeat (n) begin
      @(negedge clk);
      bus.playerDR = 1'b1;
      bus.operandDR = m;
    end
    @(negedge clk);
    bus.playerDR = 1'b0;
    bus.operandDR = 2'b00;
  endtask
  task automatic boundary(input logic [1:0] exp, input logic exp_op, input string tag,
                          input logic [1:0] sof_px = 2'b00);
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    bus.playerDR = |sof_px;
    bus.operandDR = sof_px;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.playerDR = 1'b0;
    bus.operandDR = 2'b00;
    chk({tag, ".hit"}, 32'(bus.singleHit), 32'(exp));
    chk({tag, ".valid"}, 32'(bus.hitValid), 32'(|exp));
    chk({tag, ".op"}, 32'(bus.hitOp), 32'(exp_op));
    @(negedge clk);
    chk({tag, ".clr"}, {29'd0, bus.hitValid, bus.singleHit}, 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.enable = 1'b1;
    bus.playerDR = 1'b0;
    bus.operandDR = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst.hit", 32'(bus.singleHit), 32'd0);
    chk("rst.valid", 32'(bus.hitValid), 32'd0);
    chk("rst.op", 32'(bus.hitOp), 32'd0);
    resetN = 1'b1;
    overlap(5, 2'b01);
    boundary(2'b01, 1'b0, "five_op0");
    overlap(3, 2'b10);
    boundary(2'b00, 1'b0, "three_op1");
    overlap(4, 2'b10);
    boundary(2'b10, 1'b1, "four_op1");
    repeat (4) boundary(2'b00, 1'b0, "idle1");
    for (int f = 1; f <= 6; f++) begin
      overlap(4, 2'b01);
      boundary((f == 1) ? 2'b01 : 2'b00, 1'b0, $sformatf("held_f%0d", f));
    end
    boundary(2'b00, 1'b0, "release_f7");
    overlap(4, 2'b01);
    boundary(2'b01, 1'b0, "again_f8");
    overlap(4, 2'b10);
    boundary(2'b10, 1'b1, "other_op_f1");
    overlap(4, 2'b01);
    boundary(2'b00, 1'b0, "cd_f2");
    boundary(2'b00, 1'b0, "cd_f3_rel");
    overlap(4, 2'b01);
    boundary(2'b01, 1'b0, "cd_f4");
    boundary(2'b00, 1'b0, "cd_g1");
    boundary(2'b00, 1'b0, "cd_g2");
    overlap(4, 2'b01);
    boundary(2'b00, 1'b0, "cd_g3");
    boundary(2'b00, 1'b0, "cd_g4");
    overlap(4, 2'b01);
    boundary(2'b01, 1'b0, "cd_g5");
    repeat (4) boundary(2'b00, 1'b0, "idle2");
    overlap(4, 2'b11);
    boundary(2'b11, 1'b0, "both");
    repeat (4) boundary(2'b00, 1'b0, "idle3");
    overlap(3, 2'b01);
    boundary(2'b00, 1'b0, "sof_pixel", 2'b01);
    overlap(4, 2'b01);
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    chk("b2b.first", 32'(bus.singleHit), 32'h1);
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    chk("b2b.second", 32'(bus.singleHit), 32'h0);
    chk("b2b.valid", 32'(bus.hitValid), 32'h0);
    overlap(10, 2'b10);
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    chk("midrst.hit", 32'(bus.singleHit), 32'd0);
    resetN = 1'b1;
    boundary(2'b00, 1'b0, "after_rst");
    bus.enable = 1'b0;
    overlap(6, 2'b01);
    bus.enable = 1'b1;
    boundary(2'b00, 1'b0, "en_off_count");
    overlap(4, 2'b10);
    bus.enable = 1'b0;
    boundary(2'b00, 1'b0, "en_off_eval");
    bus.enable = 1'b1;
    overlap(4, 2'b01);
    boundary(2'b01, 1'b0, "en_recover");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
